// File: rtl/node_mu_search.sv
// node_mu_search: minimisation (mu) operator over a child function node.
// Finds the smallest y in [0, limit] with f(x,y)==0 by repeatedly launching
// the child with (x, y) and inspecting its result; flags ERR when the limit
// is exhausted without a zero result.
module node_mu_search #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ST,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    output logic             RD,
    output logic [WIDTH-1:0] RES,
    output logic             ERR,
    output logic             F_ST,
    input  logic             F_RD,
    input  logic [WIDTH-1:0] F_RES,
    output logic [WIDTH-1:0] F_IN0,
    output logic [WIDTH-1:0] F_IN1
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        CHECK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             st_prev_q, st_prev_d;
    logic             armed_q, armed_d;
    logic             frd_prev_q, frd_prev_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] fres_q, fres_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             rd_q, rd_d;
    logic             err_q, err_d;
    logic             f_st_q, f_st_d;
    logic             start_evt;

    // ST must be seen low once after reset (armed) so a level held through
    // reset is not mistaken for a rising edge.
    assign start_evt = ST & ~st_prev_q & armed_q;

    // Next-state and registered-output computation for the search FSM.
    always_comb begin
        state_d    = state_q;
        st_prev_d  = ST;
        armed_d    = armed_q | ~ST;
        frd_prev_d = F_RD;
        limit_d    = limit_q;
        x_d        = x_q;
        y_d        = y_q;
        fres_d     = fres_q;
        res_d      = res_q;
        rd_d       = rd_q;
        err_d      = err_q;
        f_st_d     = f_st_q;

        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    x_d     = IN0;
                    limit_d = (IN1 == '0) ? '1 : IN1;
                    y_d     = '0;
                    rd_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                f_st_d  = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!F_RD) begin
                    f_st_d  = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (F_RD && !frd_prev_q) begin
                    fres_d  = F_RES;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (fres_q == '0) begin
                    res_d   = y_q;
                    err_d   = 1'b0;
                    rd_d    = 1'b1;
                    state_d = IDLE;
                end else if (y_q < limit_q) begin
                    y_d     = y_q + 1'b1;
                    state_d = LAUNCH;
                end else begin
                    res_d   = '1;
                    err_d   = 1'b1;
                    rd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                rd_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                rd_d    = 1'b1;
                f_st_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            st_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            frd_prev_q <= 1'b0;
            limit_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fres_q     <= '0;
            res_q      <= '0;
            rd_q       <= 1'b1;
            err_q      <= 1'b0;
            f_st_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_prev_q  <= st_prev_d;
            armed_q    <= armed_d;
            frd_prev_q <= frd_prev_d;
            limit_q    <= limit_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fres_q     <= fres_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            f_st_q     <= f_st_d;
        end
    end

    assign RD    = rd_q;
    assign RES   = res_q;
    assign ERR   = err_q;
    assign F_ST  = f_st_q;
    assign F_IN0 = x_q;
    assign F_IN1 = y_q;

endmodule

// File: tb/tb_node_mu_search.sv
// Bench for node_mu_search: a behavioural child f(x,y) = x>y ? x-y : 0 with
// fixed or random handshake timing, and a reference search model.
module tb_node_mu_search;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         st;
    logic [W-1:0] in0, in1;
    logic         rd;
    logic [W-1:0] res;
    logic         err;
    logic         f_st;
    logic         f_rd;
    logic [W-1:0] f_res;
    logic [W-1:0] f_in0, f_in1;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned last_res = 0;
    bit          rand_mode = 1'b0;

    always #5 clk = ~clk;

    node_mu_search #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST   (rst),
        .ST    (st),
        .IN0   (in0),
        .IN1   (in1),
        .RD    (rd),
        .RES   (res),
        .ERR   (err),
        .F_ST  (f_st),
        .F_RD  (f_rd),
        .F_RES (f_res),
        .F_IN0 (f_in0),
        .F_IN1 (f_in1)
    );

    // Child node. Accepts F_ST while idle, drops F_RD after drop_n cycles of
    // F_ST being high and presents its result lat cycles after F_ST rose.
    int unsigned  starts;
    int unsigned  c_t, d_n, done_n, nd, nl;
    bit           c_busy;
    logic [W-1:0] cx, cy;
    logic [W-1:0] ys_log [0:4095];
    logic [W-1:0] xs_log [0:4095];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rd   <= 1'b1;
            f_res  <= '0;
            c_busy <= 1'b0;
            c_t    <= 0;
            starts <= 0;
            nd     <= 1;
            nl     <= 3;
            d_n    <= 1;
            done_n <= 2;
            cx     <= '0;
            cy     <= '0;
        end else if (!c_busy) begin
            if (f_st) begin
                ys_log[starts % 4096] <= f_in1;
                xs_log[starts % 4096] <= f_in0;
                starts <= starts + 1;
                cx     <= f_in0;
                cy     <= f_in1;
                d_n    <= nd;
                done_n <= (nl - 1 > nd) ? nl - 1 : nd;
                if (nd == 1) f_rd <= 1'b0;
                c_t    <= 1;
                c_busy <= 1'b1;
                nd     <= rand_mode ? $urandom_range(1, 3) : 1;
                nl     <= rand_mode ? $urandom_range(1, 20) : 3;
            end
        end else begin
            if (c_t == d_n - 1) f_rd <= 1'b0;
            if (c_t == done_n) begin
                f_rd   <= 1'b1;
                f_res  <= (cx > cy) ? cx - cy : '0;
                c_busy <= 1'b0;
            end
            c_t <= c_t + 1;
        end
    end

    // F_ST must not drop while the child still showed F_RD high.
    int unsigned viol = 0;
    logic        pf, pr;
    always @(negedge clk) begin
        if (rst) begin
            pf <= 1'b0;
            pr <= 1'b1;
        end else begin
            if (pf && !f_st && pr) viol <= viol + 1;
            pf <= f_st;
            pr <= f_rd;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: walk y upward from 0 to the effective limit.
    function automatic void model(input int unsigned x, input int unsigned lim,
                                  output int unsigned r, output int unsigned e,
                                  output int unsigned n);
        int unsigned eff;
        eff = (lim == 0) ? 65535 : lim;
        r = 65535;
        e = 1;
        n = 0;
        for (int unsigned y = 0; y <= eff; y++) begin
            n++;
            if (((x > y) ? x - y : 0) == 0) begin
                r = y;
                e = 0;
                break;
            end
        end
    endfunction

    task automatic wait_rd(output int unsigned cyc);
        cyc = 0;
        while (!rd && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (!rd) check_eq("done_timeout", rd, 1);
    endtask

    task automatic check_result(input int unsigned x, input int unsigned lim,
                                input int unsigned base);
        int unsigned r, e, n;
        model(x, lim, r, e, n);
        check_eq("res", res, r);
        check_eq("err", err, e);
        check_eq("starts", starts - base, n);
        for (int unsigned i = 0; i < n && i < starts - base; i++) begin
            check_eq("y_seq", ys_log[(base + i) % 4096], i);
            check_eq("x_pass", xs_log[(base + i) % 4096], x);
        end
        last_res = r;
    endtask

    task automatic run_search(input int unsigned x, input int unsigned lim,
                              output int unsigned cyc);
        int unsigned base;
        base = starts;
        @(negedge clk);
        in0 = W'(x);
        in1 = W'(lim);
        st  = 1'b1;
        @(negedge clk);
        check_eq("rd_fall", rd, 0);
        st  = 1'b0;
        in0 = W'($urandom);
        in1 = W'($urandom);
        wait_rd(cyc);
        check_result(x, lim, base);
    endtask

    task automatic wait_y(input int unsigned yv);
        int unsigned k;
        k = 0;
        while (f_in1 != W'(yv) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_y", f_in1, yv);
    endtask

    initial begin
        int unsigned cyc, base;
        rst = 1'b1;
        st  = 1'b0;
        in0 = '0;
        in1 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd", rd, 1);
        check_eq("rst_res", res, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_fst", f_st, 0);
        check_eq("rst_fin0", f_in0, 0);
        check_eq("rst_fin1", f_in1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_search(3, 0, cyc);
        run_search(0, 0, cyc);
        check_eq("fast_done", cyc <= 6, 1);
        run_search(10, 5, cyc);

        // Start pulse while busy is ignored; result registers hold meanwhile.
        base = starts;
        @(negedge clk);
        in0 = 7; in1 = 0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        wait_y(2);
        st = 1'b1;
        check_eq("res_hold", res, last_res);
        @(negedge clk);
        st = 1'b0;
        wait_rd(cyc);
        check_result(7, 0, base);

        // Reset mid-search aborts; ST held high across release does not start.
        @(negedge clk);
        in0 = 7; in1 = 0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        wait_y(4);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_rd", rd, 1);
        check_eq("abort_res", res, 0);
        check_eq("abort_err", err, 0);
        check_eq("abort_fst", f_st, 0);
        check_eq("abort_fin1", f_in1, 0);
        st = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("no_start_starts", starts, 0);
        check_eq("no_start_rd", rd, 1);
        check_eq("no_start_fst", f_st, 0);
        st = 1'b0;
        @(negedge clk);
        run_search(2, 0, cyc);

        // Random child timing, then random arguments.
        rand_mode = 1'b1;
        run_search(3, 0, cyc);
        for (int t = 0; t < 12; t++) begin
            run_search($urandom_range(0, 30), $urandom_range(0, 40), cyc);
        end
        check_eq("fst_held", viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
